fp_result_packer: RTL and testbench

//  Downstream neighbour of the FP32->FP16 narrowing stage in the MAC result path.

---
 rtl/fp_result_packer.sv | 203 ++++++++++++++++++++
 tb/tb_fp_result_packer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_result_packer.sv
// fp_result_packer: packs FP16 results in pairs (or passes FP32 through) into
// 32-bit words, queues them in a small FIFO for tile writeback and keeps sticky
// IEEE exception flags {NV,DZ,OF,UF,NX}.
// Optional macro FP_PACK_ENTRY_FLAGS_EN: adds out_fflags, the OR of the flags of
// every result packed into the word at the FIFO head.
module fp_result_packer #(
   parameter int unsigned PARM_XLEN  = 32,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 mode,
   input  logic [PARM_XLEN-1:0] result_i,
   input  logic                 NV_in,
   input  logic                 DZ_in,
   input  logic                 OF_in,
   input  logic                 UF_in,
   input  logic                 NX_in,
   input  logic                 flush,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [PARM_XLEN-1:0] out_data,
   output logic [1:0]           out_mask,
`ifdef FP_PACK_ENTRY_FLAGS_EN
   output logic [4:0]           out_fflags,
`endif
   output logic [4:0]           fflags_o,
   input  logic                 fflags_clr
);

   localparam int unsigned HALF_W = PARM_XLEN / 2;
   localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W  = PTR_W + 1;
   localparam int unsigned FLAG_W = 5;

   typedef enum logic {ST_EMPTY, ST_HALF} state_t;

   state_t               state_q, state_nxt;
   logic [HALF_W-1:0]    held_q;
   logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q, rd_ptr_nxt;
   logic [CNT_W-1:0]     count_q, count_nxt;
   logic [PARM_XLEN-1:0] mem_data [FIFO_DEPTH];
   logic [1:0]           mem_mask [FIFO_DEPTH];

   logic                 full_c, accept_c, pop_c, push_c, latch_c;
   logic [PARM_XLEN-1:0] push_data_c, head_data_c;
   logic [1:0]           push_mask_c, head_mask_c;
   logic [FLAG_W-1:0]    in_flags_c, fflags_nxt;

`ifdef FP_PACK_ENTRY_FLAGS_EN
   logic [FLAG_W-1:0]    held_flags_q;
   logic [FLAG_W-1:0]    mem_flags [FIFO_DEPTH];
   logic [FLAG_W-1:0]    push_flags_c, head_flags_c;
`endif

   // Handshake: a held half blocks FP32 so it can be flushed out first
   always_comb begin
      in_flags_c = {NV_in, DZ_in, OF_in, UF_in, NX_in};
      full_c     = (count_q == CNT_W'(FIFO_DEPTH));
      in_ready   = ~rst & ~full_c & ~((state_q == ST_HALF) & ~mode);
      accept_c   = in_valid & in_ready;
      pop_c      = out_valid & out_ready;
   end

   // Pack decision: what (if anything) is pushed this cycle and the next pack state
   always_comb begin
      state_nxt   = state_q;
      push_c      = 1'b0;
      latch_c     = 1'b0;
      push_data_c = '0;
      push_mask_c = 2'b00;
`ifdef FP_PACK_ENTRY_FLAGS_EN
      push_flags_c = '0;
`endif
      case (state_q)
         ST_EMPTY: begin
            if (accept_c) begin
               if (!mode) begin
                  push_c      = 1'b1;
                  push_data_c = result_i;
                  push_mask_c = 2'b11;
`ifdef FP_PACK_ENTRY_FLAGS_EN
                  push_flags_c = in_flags_c;
`endif
               end else if (flush) begin
                  push_c      = 1'b1;
                  push_data_c = {HALF_W'(0), result_i[HALF_W-1:0]};
                  push_mask_c = 2'b01;
`ifdef FP_PACK_ENTRY_FLAGS_EN
                  push_flags_c = in_flags_c;
`endif
               end else begin
                  latch_c   = 1'b1;
                  state_nxt = ST_HALF;
               end
            end
         end
         ST_HALF: begin
            if (accept_c) begin
               push_c      = 1'b1;
               push_data_c = {result_i[HALF_W-1:0], held_q};
               push_mask_c = 2'b11;
               state_nxt   = ST_EMPTY;
`ifdef FP_PACK_ENTRY_FLAGS_EN
               push_flags_c = held_flags_q | in_flags_c;
`endif
            end else if (((in_valid & ~mode) | flush) & ~full_c) begin
               push_c      = 1'b1;
               push_data_c = {HALF_W'(0), held_q};
               push_mask_c = 2'b01;
               state_nxt   = ST_EMPTY;
`ifdef FP_PACK_ENTRY_FLAGS_EN
               push_flags_c = held_flags_q;
`endif
            end
         end
         default: state_nxt = ST_EMPTY;
      endcase
   end

   // FIFO bookkeeping and next head word (pushed word becomes head when queue drains)
   always_comb begin
      rd_ptr_nxt  = rd_ptr_q + PTR_W'(pop_c);
      count_nxt   = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
      head_data_c = mem_data[rd_ptr_nxt];
      head_mask_c = mem_mask[rd_ptr_nxt];
`ifdef FP_PACK_ENTRY_FLAGS_EN
      head_flags_c = mem_flags[rd_ptr_nxt];
`endif
      if (push_c && (wr_ptr_q == rd_ptr_nxt)) begin
         head_data_c = push_data_c;
         head_mask_c = push_mask_c;
`ifdef FP_PACK_ENTRY_FLAGS_EN
         head_flags_c = push_flags_c;
`endif
      end
   end

   // Sticky flags: clear wins over history but not over an incoming result
   always_comb begin
      fflags_nxt = fflags_o;
      if (accept_c) begin
         fflags_nxt = fflags_clr ? in_flags_c : (fflags_o | in_flags_c);
      end else if (fflags_clr) begin
         fflags_nxt = '0;
      end
   end

   // Pack state, pointers, registered head and sticky flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_EMPTY;
         held_q    <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_mask  <= 2'b00;
         fflags_o  <= '0;
`ifdef FP_PACK_ENTRY_FLAGS_EN
         held_flags_q <= '0;
         out_fflags   <= '0;
`endif
      end else begin
         state_q  <= state_nxt;
         rd_ptr_q <= rd_ptr_nxt;
         count_q  <= count_nxt;
         fflags_o <= fflags_nxt;
         if (latch_c) begin
            held_q <= result_i[HALF_W-1:0];
`ifdef FP_PACK_ENTRY_FLAGS_EN
            held_flags_q <= in_flags_c;
`endif
         end
         if (push_c) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         out_valid <= (count_nxt != '0);
         if (count_nxt != '0) begin
            out_data <= head_data_c;
            out_mask <= head_mask_c;
`ifdef FP_PACK_ENTRY_FLAGS_EN
            out_fflags <= head_flags_c;
`endif
         end
      end
   end

   // FIFO storage
   always_ff @(posedge clk) begin
      if (push_c) begin
         mem_data[wr_ptr_q] <= push_data_c;
         mem_mask[wr_ptr_q] <= push_mask_c;
`ifdef FP_PACK_ENTRY_FLAGS_EN
         mem_flags[wr_ptr_q] <= push_flags_c;
`endif
      end
   end

endmodule

// File: tb/tb_fp_result_packer.sv
// Bench for fp_result_packer: directed cycle table, hand-written corner
// sequences and a randomized run against a queue-based reference model.
module tb_fp_result_packer;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned DEPTH = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic            in_valid, in_ready, mode, flush;
   logic [XLEN-1:0] result_i;
   logic [4:0]      in_flags;
   logic            NV_in, DZ_in, OF_in, UF_in, NX_in;
   logic            out_valid, out_ready;
   logic [XLEN-1:0] out_data;
   logic [1:0]      out_mask;
   logic [4:0]      fflags_o;
   logic            fflags_clr;
`ifdef FP_PACK_ENTRY_FLAGS_EN
   logic [4:0]      out_fflags;
`endif

   assign {NV_in, DZ_in, OF_in, UF_in, NX_in} = in_flags;

   fp_result_packer #(.PARM_XLEN(XLEN), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .mode(mode), .result_i(result_i),
      .NV_in(NV_in), .DZ_in(DZ_in), .OF_in(OF_in), .UF_in(UF_in), .NX_in(NX_in),
      .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_mask(out_mask),
`ifdef FP_PACK_ENTRY_FLAGS_EN
      .out_fflags(out_fflags),
`endif
      .fflags_o(fflags_o), .fflags_clr(fflags_clr)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Advance to 1 time unit after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic m, input logic [31:0] r, input logic fl,
                        input logic ordy, input logic [4:0] fg, input logic clr);
      in_valid   = v;
      mode       = m;
      result_i   = r;
      flush      = fl;
      out_ready  = ordy;
      in_flags   = fg;
      fflags_clr = clr;
   endtask

   task automatic idle(input logic ordy);
      drive(1'b0, 1'b0, 32'h0, 1'b0, ordy, 5'b0, 1'b0);
   endtask

   task automatic do_reset();
      idle(1'b0);
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   typedef struct {
      logic        v;
      logic        m;
      logic [31:0] r;
      logic        fl;
      logic        ordy;
      logic        exp_rdy;
      logic        exp_ov;
      logic [31:0] exp_d;
      logic [1:0]  exp_m;
   } vec_t;

   vec_t vecs[16];

   typedef struct packed {
      logic [31:0] d;
      logic [1:0]  m;
   } word_t;

   word_t       mq[$];
   logic        m_half;
   logic [15:0] m_held;
   logic [4:0]  m_sticky;

   initial begin
      // Per-cycle table: inputs, expected in_ready before the edge, outputs after it
      vecs[0]  = '{1'b1, 1'b1, 32'h0000_3C00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 2'b00};
      vecs[1]  = '{1'b1, 1'b1, 32'h0000_4000, 1'b0, 1'b1, 1'b1, 1'b1, 32'h4000_3C00, 2'b11};
      vecs[2]  = '{1'b1, 1'b1, 32'h0000_3C00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 2'b00};
      vecs[3]  = '{1'b1, 1'b0, 32'h3F80_0000, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_3C00, 2'b01};
      vecs[4]  = '{1'b1, 1'b0, 32'h3F80_0000, 1'b0, 1'b1, 1'b1, 1'b1, 32'h3F80_0000, 2'b11};
      vecs[5]  = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 2'b00};
      vecs[6]  = '{1'b1, 1'b0, 32'h0000_00A0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_00A0, 2'b11};
      vecs[7]  = '{1'b1, 1'b0, 32'h0000_00A1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_00A0, 2'b11};
      vecs[8]  = '{1'b1, 1'b0, 32'h0000_00A2, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_00A0, 2'b11};
      vecs[9]  = '{1'b1, 1'b0, 32'h0000_00A3, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_00A0, 2'b11};
      vecs[10] = '{1'b1, 1'b0, 32'h0000_00A4, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_00A0, 2'b11};
      vecs[11] = '{1'b1, 1'b0, 32'h0000_00A4, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_00A1, 2'b11};
      vecs[12] = '{1'b1, 1'b0, 32'h0000_00A4, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_00A2, 2'b11};
      vecs[13] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_00A3, 2'b11};
      vecs[14] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_00A4, 2'b11};
      vecs[15] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 2'b00};

      // Reset state
      idle(1'b0);
      rst = 1'b1;
      #3;
      check("reset_in_ready", 32'(in_ready), 32'd0);
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_out_data", out_data, 32'h0);
      check("reset_out_mask", 32'(out_mask), 32'd0);
      check("reset_fflags", 32'(fflags_o), 32'd0);
      tick();
      tick();
      rst = 1'b0;

      // Directed table: FP16 pairing, auto-flush before FP32, full FIFO back-pressure
      for (int i = 0; i < 16; i++) begin
         drive(vecs[i].v, vecs[i].m, vecs[i].r, vecs[i].fl, vecs[i].ordy, 5'b0, 1'b0);
         #1;
         check($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].exp_rdy));
         tick();
         check($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].exp_ov));
         if (vecs[i].exp_ov) begin
            check($sformatf("vec%0d_out_data", i), out_data, vecs[i].exp_d);
            check($sformatf("vec%0d_out_mask", i), 32'(out_mask), 32'(vecs[i].exp_m));
         end
      end

      // Reset mid-stream with three words queued
      do_reset();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0, 32'h100 + 32'(i), 1'b0, 1'b0, 5'b00001, 1'b0);
         tick();
      end
      idle(1'b0);
      #1;
      check("midrst_pre_valid", 32'(out_valid), 32'd1);
      check("midrst_pre_fflags", 32'(fflags_o), 32'd1);
      rst = 1'b1;
      #1;
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_fflags", 32'(fflags_o), 32'd0);
      check("midrst_in_ready", 32'(in_ready), 32'd0);
      tick();
      rst = 1'b0;
      drive(1'b1, 1'b0, 32'h0000_0777, 1'b0, 1'b1, 5'b0, 1'b0);
      #1;
      check("postrst_in_ready", 32'(in_ready), 32'd1);
      tick();
      check("postrst_word", out_data, 32'h0000_0777);

      // Sticky flag accumulation and clear
      do_reset();
      drive(1'b1, 1'b1, 32'h0000_7BFF, 1'b0, 1'b1, 5'b00100, 1'b0);
      tick();
      drive(1'b1, 1'b1, 32'h0000_0001, 1'b0, 1'b1, 5'b00001, 1'b0);
      tick();
      idle(1'b1);
      check("sticky_of_nx", 32'(fflags_o), 32'h05);
      drive(1'b1, 1'b0, 32'h7FC0_0000, 1'b0, 1'b1, 5'b10000, 1'b1);
      tick();
      idle(1'b1);
      check("sticky_clr_with_nv", 32'(fflags_o), 32'h10);
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 5'b0, 1'b1);
      tick();
      idle(1'b1);
      check("sticky_clr_alone", 32'(fflags_o), 32'h00);

      // Flushed lone FP16 against a full FIFO, released by one pop
      do_reset();
      for (int i = 1; i <= 4; i++) begin
         drive(1'b1, 1'b0, 32'h11 * 32'(i), 1'b0, 1'b0, 5'b0, 1'b0);
         tick();
      end
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 1'b1, 32'h0000_7C00, 1'b1, 1'b0, 5'b0, 1'b0);
         #1;
         check("full_flush_in_ready", 32'(in_ready), 32'd0);
         tick();
         check("full_flush_head", out_data, 32'h11);
      end
      drive(1'b1, 1'b1, 32'h0000_7C00, 1'b1, 1'b1, 5'b0, 1'b0);
      #1;
      check("full_pop_no_bypass", 32'(in_ready), 32'd0);
      tick();
      drive(1'b1, 1'b1, 32'h0000_7C00, 1'b1, 1'b0, 5'b0, 1'b0);
      #1;
      check("after_pop_in_ready", 32'(in_ready), 32'd1);
      tick();
      idle(1'b1);
      for (int i = 2; i <= 4; i++) begin
         #1;
         check("drain_data", out_data, 32'h11 * 32'(i));
         check("drain_mask", 32'(out_mask), 32'd3);
         tick();
      end
      #1;
      check("lone_valid", 32'(out_valid), 32'd1);
      check("lone_data", out_data, 32'h0000_7C00);
      check("lone_mask", 32'(out_mask), 32'd1);
      tick();
      check("drained_valid", 32'(out_valid), 32'd0);

      // Randomized run against the queue model
      do_reset();
      mq.delete();
      m_half   = 1'b0;
      m_held   = 16'h0;
      m_sticky = 5'h0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         logic        v, m, fl, ordy, clr, exp_rdy, acc, pop, full, push;
         logic [31:0] r;
         logic [4:0]  fg;
         word_t       w;
         v    = ($urandom_range(0, 3) != 0);
         m    = 1'($urandom_range(0, 1));
         r    = $urandom;
         fl   = ($urandom_range(0, 7) == 0);
         ordy = ($urandom_range(0, 2) != 0);
         fg   = 5'($urandom & $urandom & $urandom);
         clr  = ($urandom_range(0, 15) == 0);
         drive(v, m, r, fl, ordy, fg, clr);
         #1;
         exp_rdy = (mq.size() < DEPTH) && !(m_half && !m);
         check("rnd_in_ready", 32'(in_ready), 32'(exp_rdy));
         check("rnd_out_valid", 32'(out_valid), 32'(mq.size() != 0));
         check("rnd_fflags", 32'(fflags_o), 32'(m_sticky));
         if (mq.size() != 0) begin
            check("rnd_out_data", out_data, mq[0].d);
            check("rnd_out_mask", 32'(out_mask), 32'(mq[0].m));
         end
         full = (mq.size() == DEPTH);
         acc  = v && exp_rdy;
         pop  = (mq.size() != 0) && ordy;
         push = 1'b0;
         w    = '0;
         if (!m_half) begin
            if (acc && !m) begin
               push = 1'b1;
               w    = '{r, 2'b11};
            end else if (acc && fl) begin
               push = 1'b1;
               w    = '{{16'h0, r[15:0]}, 2'b01};
            end else if (acc) begin
               m_half = 1'b1;
               m_held = r[15:0];
            end
         end else if (acc) begin
            push   = 1'b1;
            w      = '{{r[15:0], m_held}, 2'b11};
            m_half = 1'b0;
         end else if (((v && !m) || fl) && !full) begin
            push   = 1'b1;
            w      = '{{16'h0, m_held}, 2'b01};
            m_half = 1'b0;
         end
         if (acc) m_sticky = clr ? fg : (m_sticky | fg);
         else if (clr) m_sticky = 5'h0;
         tick();
         if (pop) void'(mq.pop_front());
         if (push) mq.push_back(w);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
